// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a one-deep holding register.
//
// Frame: start bit (0), DATA_BITS data bits (LSB or MSB first), optional
// parity bit (odd/even), STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT
// clocks. When a word is already held at the end of the last stop bit, the
// next start bit follows immediately, so back-to-back frames have no idle gap.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   tx_data      word to transmit (DATA_BITS wide)
//   tx_valid     tx_data valid
//   tx_ready     holding register empty; accept = tx_valid && tx_ready at posedge
//   tx_out       serial line, idle high (registered)
//   busy         high while the transmitter is not idle (registered)
//   done         one-cycle pulse during the final cycle of the last stop bit
//   parity_en_o  constant, high when a parity bit is sent
//
// state  | meaning
// IDLE   | line high, waiting for a held word
// START  | sending the start bit (0)
// DATA   | sending data bits from the shifter
// PARITY | sending the parity bit
// STOP   | sending stop bit(s) (1)

module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int LSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done,
    output logic                 parity_en_o
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shifter, shifter_nxt;
    logic                 par_bit, par_nxt;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full, hold_full_nxt;
    logic                 tx_out_nxt, done_nxt;
    logic                 expired, load, shift, accept;

    assign parity_en_o = (PARITY_MODE != 0);
    assign expired     = (timer == '0);
    assign accept      = tx_valid && !hold_full;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = expired ? '0 : timer - 1'b1;
        bit_cnt_nxt = bit_cnt;
        load        = 1'b0;
        shift       = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    state_nxt = S_START;
                    load      = 1'b1;
                    timer_nxt = T_RELOAD;
                end
            end
            S_START: begin
                if (expired) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                    timer_nxt   = T_RELOAD;
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift     = 1'b1;
                    timer_nxt = T_RELOAD;
                    if (bit_cnt == 4'(DATA_BITS - 1)) begin
                        state_nxt   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (expired) begin
                    state_nxt   = S_STOP;
                    bit_cnt_nxt = '0;
                    timer_nxt   = T_RELOAD;
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        if (hold_full) begin
                            state_nxt = S_START;
                            load      = 1'b1;
                            timer_nxt = T_RELOAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        timer_nxt   = T_RELOAD;
                    end
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                timer_nxt   = '0;
                bit_cnt_nxt = '0;
            end
        endcase
    end

    // Shifter, parity and the registered line value are all derived from the
    // next state so that tx_out changes on the same edge as the state.
    always_comb begin
        shifter_nxt = shifter;
        par_nxt     = par_bit;
        if (load) begin
            shifter_nxt = hold;
            par_nxt     = (^hold) ^ (PARITY_MODE == 1);
        end else if (shift) begin
            if (LSB_FIRST != 0) shifter_nxt = {1'b0, shifter[DATA_BITS-1:1]};
            else                shifter_nxt = {shifter[DATA_BITS-2:0], 1'b0};
        end

        hold_full_nxt = hold_full;
        if (load)   hold_full_nxt = 1'b0;
        if (accept) hold_full_nxt = 1'b1;

        case (state_nxt)
            S_START:  tx_out_nxt = 1'b0;
            S_DATA:   tx_out_nxt = (LSB_FIRST != 0) ? shifter_nxt[0] : shifter_nxt[DATA_BITS-1];
            S_PARITY: tx_out_nxt = par_nxt;
            default:  tx_out_nxt = 1'b1;
        endcase

        // High during the final clock of the last stop bit.
        done_nxt = (state_nxt == S_STOP) && (timer_nxt == '0) &&
                   (bit_cnt_nxt == 4'(STOP_BITS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            par_bit   <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shifter   <= shifter_nxt;
            par_bit   <= par_nxt;
            if (accept) hold <= tx_data;
            hold_full <= hold_full_nxt;
            tx_ready  <= !hold_full_nxt;
            tx_out    <= tx_out_nxt;
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations run side by side, each checked
// every cycle against a frame-level model (bit vector + cycle position), plus
// hand-computed line waveforms for the directed cases.
//   inst0: 8N1, CLKS_PER_BIT=4, LSB first
//   inst1: 8E1, CLKS_PER_BIT=4
//   inst2: 8O1, CLKS_PER_BIT=4
//   inst3: 7N2, CLKS_PER_BIT=3, MSB first

module tb_uart_tx_param;

    localparam int N = 4;
    localparam int CDB   [N] = '{8, 8, 8, 7};
    localparam int CPAR  [N] = '{0, 2, 1, 0};
    localparam int CSTOP [N] = '{1, 1, 1, 2};
    localparam int CCPB  [N] = '{4, 4, 4, 3};
    localparam int CLSB  [N] = '{1, 1, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] tx_data_v [N];
    logic [N-1:0] tx_valid_v;
    logic [N-1:0] tx_ready_v, tx_out_v, busy_v, done_v, par_en_v;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_param #(
            .DATA_BITS(CDB[g]), .PARITY_MODE(CPAR[g]), .STOP_BITS(CSTOP[g]),
            .CLKS_PER_BIT(CCPB[g]), .LSB_FIRST(CLSB[g])
        ) u_dut (
            .clk(clk), .rst(rst),
            .tx_data(tx_data_v[g][CDB[g]-1:0]), .tx_valid(tx_valid_v[g]),
            .tx_ready(tx_ready_v[g]), .tx_out(tx_out_v[g]), .busy(busy_v[g]),
            .done(done_v[g]), .parity_en_o(par_en_v[g])
        );
    end

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, i, $time, act, exp);
        end
    endtask

    // Frame as a list of line levels, one entry per bit, index 0 sent first.
    function automatic void build(input int i, input logic [8:0] d, output logic [15:0] b, output int len);
        int k;
        logic p;
        b = '0;
        k = 1;
        p = 1'b0;
        for (int j = 0; j < CDB[i]; j++) begin
            b[k] = (CLSB[i] != 0) ? d[j] : d[CDB[i]-1-j];
            p    = p ^ d[j];
            k++;
        end
        if (CPAR[i] == 1) begin b[k] = ~p; k++; end
        if (CPAR[i] == 2) begin b[k] = p;  k++; end
        for (int s = 0; s < CSTOP[i]; s++) begin b[k] = 1'b1; k++; end
        len = k;
    endfunction

    // Model state: holding register plus the frame in flight and how many
    // clocks of it have elapsed.
    logic [15:0] m_bits [N];
    int          m_len  [N];
    int          m_cyc  [N];
    logic        m_act  [N];
    logic        m_full [N];
    logic        m_acc  [N];
    logic [8:0]  m_hold [N];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_act[i] = 1'b0; m_full[i] = 1'b0; m_acc[i] = 1'b0;
                m_cyc[i] = 0; m_len[i] = 0; m_bits[i] = '0; m_hold[i] = '0;
            end else begin
                m_acc[i] = tx_valid_v[i] && !m_full[i];
                if (m_act[i]) begin
                    m_cyc[i]++;
                    if (m_cyc[i] == m_len[i] * CCPB[i]) m_act[i] = 1'b0;
                end
                if (!m_act[i] && m_full[i]) begin
                    build(i, m_hold[i], m_bits[i], m_len[i]);
                    m_act[i]  = 1'b1;
                    m_cyc[i]  = 0;
                    m_full[i] = 1'b0;
                end
                if (m_acc[i]) begin
                    m_full[i] = 1'b1;
                    m_hold[i] = tx_data_v[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic e_tx, e_done;
                e_tx   = m_act[i] ? m_bits[i][m_cyc[i] / CCPB[i]] : 1'b1;
                e_done = m_act[i] && (m_cyc[i] == m_len[i] * CCPB[i] - 1);
                chk("tx_out", i, 64'(tx_out_v[i]), 64'(e_tx));
                chk("busy", i, 64'(busy_v[i]), 64'(m_act[i]));
                chk("done", i, 64'(done_v[i]), 64'(e_done));
                chk("tx_ready", i, 64'(tx_ready_v[i]), 64'(!m_full[i]));
            end
        end
    end

    task automatic capture(input int i, input logic [8:0] d, input int n,
                           output logic [63:0] line, output int done_at);
        @(negedge clk);
        tx_data_v[i]  = d;
        tx_valid_v[i] = 1'b1;
        @(negedge clk);
        tx_valid_v[i] = 1'b0;
        chk("ready_after_accept", i, 64'(tx_ready_v[i]), 64'd0);
        line    = '0;
        done_at = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            line[n-1-k] = tx_out_v[i];
            if (done_v[i]) done_at = k;
        end
    endtask

    initial begin
        logic [63:0] line;
        logic [15:0] mb;
        int ml, dat, d1, d2, ndone, nacc;
        logic [8:0] word;

        tx_valid_v = '0;
        for (int i = 0; i < N; i++) tx_data_v[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 0, 64'(tx_out_v), 64'hF);
        chk("rst_ready", 0, 64'(tx_ready_v), 64'hF);
        chk("rst_busy", 0, 64'(busy_v), 64'h0);
        chk("rst_done", 0, 64'(done_v), 64'h0);
        chk("parity_en", 0, 64'(par_en_v), 64'b0110);
        rst = 1'b0;
        chk_en = 1'b1;

        // model pins
        build(0, 9'h0A5, mb, ml);
        chk("model_a5_bits", 0, 64'(mb), 64'h034A);
        chk("model_a5_len", 0, 64'(ml), 64'd10);
        build(2, 9'h007, mb, ml);
        chk("model_odd_len", 2, 64'(ml), 64'd11);

        // 8N1 0xA5
        capture(0, 9'h0A5, 40, line, dat);
        chk("a5_line", 0, line & 64'hFF_FFFF_FFFF, 64'h0F0F00F0FF);
        chk("a5_done_at", 0, 64'(dat), 64'd39);
        repeat (3) @(negedge clk);

        // parity on 0x07
        capture(1, 9'h007, 44, line, dat);
        chk("even_line", 1, line & 64'hFFF_FFFF_FFFF, 64'h0FFF00000FF);
        chk("even_done_at", 1, 64'(dat), 64'd43);
        capture(2, 9'h007, 44, line, dat);
        chk("odd_line", 2, line & 64'hFFF_FFFF_FFFF, 64'h0FFF000000F);
        chk("odd_done_at", 2, 64'(dat), 64'd43);

        // 7 data bits, MSB first, 2 stop bits, 3 clocks per bit: 10 bits = 30 clocks
        capture(3, 9'h041, 30, line, dat);
        chk("msb7_line", 3, line & 64'h3FFF_FFFF, 64'(30'b000111000000000000000111111111));
        chk("msb7_done_at", 3, 64'(dat), 64'd29);
        repeat (3) @(negedge clk);

        // back-to-back 0x55 then 0xAA
        @(negedge clk); tx_data_v[0] = 9'h055; tx_valid_v[0] = 1'b1;
        @(negedge clk); tx_valid_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        tx_data_v[0] = 9'h0AA; tx_valid_v[0] = 1'b1;
        @(negedge clk); tx_valid_v[0] = 1'b0;
        chk("b2b_ready_low", 0, 64'(tx_ready_v[0]), 64'd0);
        d1 = -1; d2 = -1;
        for (int k = 0; k < 120 && d2 < 0; k++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    chk("b2b_ready_at_stop", 0, 64'(tx_ready_v[0]), 64'd0);
                    @(negedge clk);
                    chk("b2b_no_gap", 0, 64'(tx_out_v[0]), 64'd0);
                    chk("b2b_ready_after_load", 0, 64'(tx_ready_v[0]), 64'd1);
                end else begin
                    d2 = cyc;
                end
            end
        end
        chk("b2b_second_done_seen", 0, 64'(d2 >= 0), 64'd1);
        chk("b2b_done_spacing", 0, 64'(d2 - d1), 64'd40);
        repeat (45) @(negedge clk);

        // reset in DATA with a word held
        @(negedge clk); tx_data_v[0] = 9'h03C; tx_valid_v[0] = 1'b1;
        @(negedge clk); tx_valid_v[0] = 1'b0;
        repeat (8) @(negedge clk);
        tx_data_v[0] = 9'h0C3; tx_valid_v[0] = 1'b1;
        @(negedge clk); tx_valid_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx_out", 0, 64'(tx_out_v[0]), 64'd1);
        chk("rst_mid_ready", 0, 64'(tx_ready_v[0]), 64'd1);
        chk("rst_mid_busy", 0, 64'(busy_v[0]), 64'd0);
        chk("rst_mid_done", 0, 64'(done_v[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) ndone++;
        end
        chk("rst_held_word_dropped", 0, 64'(ndone), 64'd0);
        capture(0, 9'h096, 40, line, dat);
        chk("post_rst_line", 0, line & 64'hFF_FFFF_FFFF, 64'h00FF0F00FF);
        repeat (3) @(negedge clk);

        // tx_valid held high, incrementing word
        @(negedge clk); word = 9'h010; tx_data_v[0] = word; tx_valid_v[0] = 1'b1;
        ndone = 0; nacc = 0;
        for (int k = 0; k < 161; k++) begin
            @(negedge clk);
            if (m_acc[0]) begin word = word + 1'b1; tx_data_v[0] = word; nacc++; end
            if (done_v[0]) ndone++;
        end
        tx_valid_v[0] = 1'b0;
        chk("stream_done_count", 0, 64'(ndone), 64'd4);
        chk("stream_accept_count", 0, 64'(nacc), 64'd5);
        repeat (90) @(negedge clk);

        // random traffic on all instances
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) tx_valid_v[i] = 1'b0;
                if (!tx_valid_v[i] && $urandom_range(0, 3) == 0) begin
                    tx_data_v[i]  = 9'($urandom);
                    tx_valid_v[i] = 1'b1;
                end
            end
        end
        tx_valid_v = '0;
        repeat (120) @(negedge clk);
        chk("drained_idle", 0, 64'(busy_v), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
